mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit.
- Consumes the two register-file read operands plus the destination index from decode.
- Produces a one-cycle write-back request (enable, address, data) for the register-file write port.
- Raises busy so the core stalls its PC while an operation is in flight.

Parameters:
XLEN, 32, operand/result width; must equal CPU_WIDTH.
RADDR_W, 5, register address width; must equal REG_ADDR_WIDTH.

Ports:
clk  input  1  clock, rising edge.
rstn  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a  input  XLEN  rs1 data (multiplicand/dividend).
op_b  input  XLEN  rs2 data (multiplier/divisor).
rd_in  input  RADDR_W  destination register.
flush  input  1  synchronous abort.
busy  output  1  high in CALC and DONE.
result_valid  output  1  one-cycle pulse, result ready.
wb_en  output  1  equals result_valid; drives register-file write_en.
wb_addr  output  RADDR_W  latched rd_in.
wb_data  output  XLEN  result.

Behaviour:
- Reset is asynchronous on rstn low:
  - state=IDLE; all outputs 0; internal regs 0.
  - Reset mid-operation discards the operation; no write-back.
- States are IDLE, CALC and DONE, registered and 2-bit encoded.
- IDLE:
  - On start=1, latch funct3, rd_in, operand magnitudes and result sign.
  - Special cases go to DONE directly; otherwise go to CALC with count=XLEN-1.
  - start=0: stay in IDLE.
- Special cases (IDLE->DONE, result available the next cycle):
  - DIV/DIVU with op_b=0: quotient 0xFFFFFFFF.
  - REM/REMU with op_b=0: op_a.
  - DIV with op_a=0x80000000 and op_b=0xFFFFFFFF: quotient 0x80000000.
  - REM with op_a=0x80000000 and op_b=0xFFFFFFFF: 0.
- CALC runs one bit per cycle.
  - Multiply: shift-add on unsigned magnitudes into a 2*XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle, XLEN-bit remainder with a borrow bit.
  - When count==0: apply sign correction (two's-complement negate), select the half (MUL low; MULH* high) or quotient/remainder, load wb_data, go to DONE.
  - Otherwise decrement count.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - DIV: quotient negated when operand signs differ.
  - REM: remainder takes the dividend's sign.
  - Unsigned ops: no correction.
- DONE:
  - result_valid=wb_en=1 for exactly one cycle; wb_addr/wb_data stable.
  - Then go to IDLE.
  - wb_data holds its value until the next DONE.
- Latency from the start-sampling edge:
  - Normal ops: result_valid high in cycle XLEN+1 (33 for XLEN=32).
  - Special cases: result_valid high in cycle 1.
  - Throughput: a new start is accepted in the cycle after DONE.
- start while busy is ignored; no queueing.
- Operand changes after the start edge have no effect.
- flush=1:
  - From any state, next state is IDLE with result_valid=0.
  - flush has priority over start and over DONE's pulse; if flush is high in DONE, no wb_en.
- rd_in=0: computed normally, wb_en still pulses; the register file discards writes to x0.

Optional Feature:
MDU_FAST_MUL_EN
- Defined:
  - MUL/MULH/MULHSU/MULHU are computed with a single 2*XLEN signed multiplier in IDLE and go straight to DONE (latency 1).
  - Division is unchanged.
- Undefined: all multiplies use the iterative CALC path (latency XLEN+1); no multiplier is inferred.

Decomposition:
- riscv_define.v holds:
  - funct3 op codes (MDU_MUL..MDU_REMU)
  - state encodings (MDU_IDLE, MDU_CALC, MDU_DONE)
  - CPU_WIDTH and REG_ADDR_WIDTH
- Sub-module mdu_step: purely combinational single-iteration datapath.
  - Inputs: mode, accumulator/remainder, operand.
  - Outputs: next accumulator/remainder and quotient bit.
  - Instantiated once.
- FSM, counter and sign handling stay in mdu_iter.

Test Plan:
1. MUL, a=7, b=-3, rd=5 -> result_valid at cycle 33; wb_data=0xFFFFFFEB, wb_addr=5; one-cycle pulse.
2. MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
3. DIV -7/2 -> 0xFFFFFFFD. REM -7%2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100%7 -> 2.
4. DIV by 0 (a=5) -> 0xFFFFFFFF at cycle 1. REM by 0 -> 5. DIV 0x80000000/-1 -> 0x80000000 at cycle 1.
5. start during CALC with different operands -> ignored, first result correct. flush at cycle 10 -> no wb_en, busy=0 the next cycle, a new start is accepted.
6. rstn low at cycle 15 of a DIV -> all outputs 0 immediately, no pulse after release. With MDU_FAST_MUL_EN, MUL 7×-3 -> 0xFFFFFFEB at cycle 1.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// widths, funct3 op codes and FSM state encodings.
package mdu_iter_pkg;

    localparam int unsigned CPU_WIDTH      = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        MduMul    = 3'b000,
        MduMulh   = 3'b001,
        MduMulhsu = 3'b010,
        MduMulhu  = 3'b011,
        MduDiv    = 3'b100,
        MduDivu   = 3'b101,
        MduRem    = 3'b110,
        MduRemu   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        MduIdle = 2'b00,
        MduCalc = 2'b01,
        MduDone = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_if.sv
// Decode-side request and register-file write-back bundle for mdu_iter.
interface mdu_iter_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
);
    logic               start;
    logic [2:0]         funct3;
    logic [XLEN-1:0]    op_a;
    logic [XLEN-1:0]    op_b;
    logic [RADDR_W-1:0] rd_in;
    logic               flush;
    logic               busy;
    logic               result_valid;
    logic               wb_en;
    logic [RADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]    wb_data;

    modport master (
        output start, funct3, op_a, op_b, rd_in, flush,
        input  busy, result_valid, wb_en, wb_addr, wb_data
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in, flush,
        output busy, result_valid, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring divide step on unsigned magnitudes.
module mdu_step
    import mdu_iter_pkg::*;
#(
    parameter int unsigned XLEN = CPU_WIDTH
) (
    input  logic              mode_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next,
    output logic              q_bit
);

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] diff;
    logic            borrow;

    always_comb begin
        add_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        borrow    = rem_shift < {1'b0, operand};
        // Without borrow the true difference is below operand, so XLEN bits suffice.
        diff      = rem_shift[XLEN-1:0] - operand;
        q_bit     = 1'b0;
        if (mode_div) begin
            q_bit    = ~borrow;
            acc_next = {(borrow ? rem_shift[XLEN-1:0] : diff), acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {add_sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit with register-file write-back.
// Define MDU_FAST_MUL_EN to compute multiplies in a single cycle.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int unsigned XLEN    = CPU_WIDTH,
    parameter int unsigned RADDR_W = REG_ADDR_WIDTH
) (
    input logic       clk,
    input logic       rstn,
    mdu_iter_if.slave bus
);

    localparam int unsigned   CW     = $clog2(XLEN);
    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e         state;
    logic [2:0]         op_q;
    logic [RADDR_W-1:0] rd_q;
    logic [RADDR_W-1:0] wb_addr_q;
    logic [XLEN-1:0]    wb_data_q;
    logic [2*XLEN-1:0]  acc_q;
    logic [XLEN-1:0]    opd_q;
    logic [CW-1:0]      count_q;
    logic               neg_q;
    logic               busy_q;
    logic               rv_q;

    logic              a_signed, b_signed, a_neg, b_neg, is_div, special, neg_d;
    logic [XLEN-1:0]   a_mag, b_mag, special_val, div_sel, calc_res;
    logic [2*XLEN-1:0] step_acc, acc_fin, prod_fix;
    logic              step_q;

    always_comb begin
        a_signed = (bus.funct3 == MduMulh) || (bus.funct3 == MduMulhsu) ||
                   (bus.funct3 == MduDiv)  || (bus.funct3 == MduRem);
        b_signed = (bus.funct3 == MduMulh) || (bus.funct3 == MduDiv) ||
                   (bus.funct3 == MduRem);
        a_neg    = a_signed & bus.op_a[XLEN-1];
        b_neg    = b_signed & bus.op_b[XLEN-1];
        a_mag    = a_neg ? -bus.op_a : bus.op_a;
        b_mag    = b_neg ? -bus.op_b : bus.op_b;
        is_div   = bus.funct3[2];
        // Remainder follows the dividend; quotient and products follow the sign product.
        neg_d    = (bus.funct3 == MduRem) ? a_neg : (a_neg ^ b_neg);
        special  = 1'b0;
        special_val = '0;
        if (is_div && bus.op_b == '0) begin
            special     = 1'b1;
            special_val = bus.funct3[1] ? bus.op_a : '1;
        end else if (is_div && !bus.funct3[0] && bus.op_a == IntMin && bus.op_b == '1) begin
            special     = 1'b1;
            special_val = bus.funct3[1] ? '0 : IntMin;
        end
    end

    mdu_step #(
        .XLEN (XLEN)
    ) u_step (
        .mode_div (op_q[2]),
        .acc      (acc_q),
        .operand  (opd_q),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    always_comb begin
        acc_fin  = {step_acc[2*XLEN-1:1], op_q[2] ? step_q : step_acc[0]};
        prod_fix = neg_q ? -acc_fin : acc_fin;
        div_sel  = op_q[1] ? acc_fin[2*XLEN-1:XLEN] : acc_fin[XLEN-1:0];
        if (op_q[2]) begin
            calc_res = neg_q ? -div_sel : div_sel;
        end else begin
            calc_res = (op_q == MduMul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]   fast_res;
    always_comb begin
        fast_a    = {{XLEN{a_neg}}, bus.op_a};
        fast_b    = {{XLEN{b_neg}}, bus.op_b};
        fast_prod = fast_a * fast_b;
        fast_res  = (bus.funct3 == MduMul) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= MduIdle;
            op_q      <= '0;
            rd_q      <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            rv_q      <= 1'b0;
        end else if (bus.flush) begin
            state  <= MduIdle;
            busy_q <= 1'b0;
            rv_q   <= 1'b0;
        end else begin
            unique case (state)
                MduIdle: begin
                    if (bus.start) begin
                        op_q    <= bus.funct3;
                        rd_q    <= bus.rd_in;
                        neg_q   <= neg_d;
                        acc_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        opd_q   <= is_div ? b_mag : a_mag;
                        count_q <= CW'(XLEN - 1);
                        busy_q  <= 1'b1;
                        if (special) begin
                            wb_data_q <= special_val;
                            wb_addr_q <= bus.rd_in;
                            rv_q      <= 1'b1;
                            state     <= MduDone;
`ifdef MDU_FAST_MUL_EN
                        end else if (!is_div) begin
                            wb_data_q <= fast_res;
                            wb_addr_q <= bus.rd_in;
                            rv_q      <= 1'b1;
                            state     <= MduDone;
`endif
                        end else begin
                            state <= MduCalc;
                        end
                    end
                end
                MduCalc: begin
                    acc_q <= acc_fin;
                    if (count_q == '0) begin
                        wb_data_q <= calc_res;
                        wb_addr_q <= rd_q;
                        rv_q      <= 1'b1;
                        state     <= MduDone;
                    end else begin
                        count_q <= count_q - CW'(1);
                    end
                end
                MduDone: begin
                    rv_q   <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= MduIdle;
                end
                default: state <= MduIdle;
            endcase
        end
    end

    // A flush arriving in DONE must suppress the write that is already registered.
    assign bus.result_valid = rv_q & ~bus.flush;
    assign bus.wb_en        = rv_q & ~bus.flush;
    assign bus.busy         = busy_q;
    assign bus.wb_addr      = wb_addr_q;
    assign bus.wb_data      = wb_data_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter; expected values are hand-computed.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 33;
`endif

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;
    int   poke_cyc;

    mdu_iter_if #(.XLEN(32), .RADDR_W(5)) bus ();

    mdu_iter dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the start-sampling edge.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.op_a   = 32'hDEAD_BEEF;
        bus.op_b   = 32'h0;
        bus.rd_in  = 5'd31;
        bus.funct3 = 3'b111;
    endtask

    task automatic wait_result(input string tag, input logic [31:0] exp_data,
                               input logic [4:0] exp_addr, input int exp_lat);
        int cyc;
        cyc = 1;
        while (!bus.result_valid && cyc < 40) begin
            if (cyc == poke_cyc) begin
                bus.start  = 1'b1;
                bus.funct3 = MduMul;
                bus.op_a   = 32'd7;
                bus.op_b   = 32'hFFFF_FFFD;
                bus.rd_in  = 5'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " wb_en"}, 64'(bus.wb_en), 64'd1);
        check({tag, " data"}, 64'(bus.wb_data), 64'(exp_data));
        check({tag, " addr"}, 64'(bus.wb_addr), 64'(exp_addr));
        @(posedge clk);
        #1;
        check({tag, " pulse end"}, 64'(bus.result_valid), 64'd0);
        check({tag, " busy end"}, 64'(bus.busy), 64'd0);
        check({tag, " data hold"}, 64'(bus.wb_data), 64'(exp_data));
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_data, input int exp_lat);
        start_op(f, a, b, rd);
        wait_result(tag, exp_data, rd, exp_lat);
    endtask

    initial begin
        int pulses;
        n_tests    = 0;
        n_fail     = 0;
        poke_cyc   = 0;
        rstn       = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'b000;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.rd_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset valid", 64'(bus.result_valid), 64'd0);
        check("reset wb_en", 64'(bus.wb_en), 64'd0);
        check("reset data", 64'(bus.wb_data), 64'd0);
        check("reset addr", 64'(bus.wb_addr), 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul", MduMul, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MulLat);
        run_op("mulh", MduMulh, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, MulLat);
        run_op("mulhu", MduMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, MulLat);
        run_op("mulhsu", MduMulhsu, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, MulLat);
        run_op("mul x0", MduMul, 32'd6, 32'd7, 5'd0, 32'd42, MulLat);
        run_op("div", MduDiv, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33);
        run_op("rem", MduRem, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33);
        run_op("divu", MduDivu, 32'd100, 32'd7, 5'd12, 32'd14, 33);
        run_op("remu", MduRemu, 32'd100, 32'd7, 5'd13, 32'd2, 33);
        run_op("divu big", MduDivu, 32'hFFFF_FFFF, 32'h10, 5'd14, 32'h0FFF_FFFF, 33);
        run_op("remu big", MduRemu, 32'hFFFF_FFFF, 32'h10, 5'd15, 32'hF, 33);
        run_op("div0", MduDiv, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF, 1);
        run_op("rem0", MduRem, 32'd5, 32'd0, 5'd17, 32'd5, 1);
        run_op("divu0", MduDivu, 32'd9, 32'd0, 5'd18, 32'hFFFF_FFFF, 1);
        run_op("div ovf", MduDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1);
        run_op("rem ovf", MduRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0, 1);

        // A start while busy must not disturb the running operation.
        start_op(MduDivu, 32'd100, 32'd7, 5'd5);
        poke_cyc = 5;
        wait_result("busy start", 32'd14, 5'd5, 33);
        poke_cyc = 0;

        // Flush in CALC at cycle 10.
        start_op(MduDiv, 32'd100, 32'd7, 5'd3);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush busy", 64'(bus.busy), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.wb_en) pulses++;
            @(posedge clk);
            #1;
        end
        check("flush no wb", 64'(pulses), 64'd0);
        run_op("after flush", MduDivu, 32'd100, 32'd7, 5'd4, 32'd14, 33);

        // Flush coinciding with DONE suppresses the write.
        start_op(MduDiv, 32'd5, 32'd0, 5'd21);
        bus.flush = 1'b1;
        #1;
        check("flush done wb_en", 64'(bus.wb_en), 64'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush done busy", 64'(bus.busy), 64'd0);
        check("flush done valid", 64'(bus.result_valid), 64'd0);

        // Asynchronous reset in cycle 15 of a divide.
        start_op(MduDiv, 32'd100, 32'd7, 5'd22);
        repeat (14) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst valid", 64'(bus.result_valid), 64'd0);
        check("rst wb_en", 64'(bus.wb_en), 64'd0);
        check("rst data", 64'(bus.wb_data), 64'd0);
        check("rst addr", 64'(bus.wb_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn   = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.wb_en) pulses++;
            @(posedge clk);
            #1;
        end
        check("rst no wb", 64'(pulses), 64'd0);
        run_op("after rst", MduMul, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MulLat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
